// File: rtl/reset_clock_manager_if.sv
// Control/status bundle between the reset/clock manager and its host.
// The manager connects through the slave modport.
interface reset_clock_manager_if #(
  parameter int Channels  = 4,
  parameter int AddrWidth = 2,
  parameter int DivWidth  = 8
);
  logic                 softReset;
  logic                 divWe;
  logic [AddrWidth-1:0] divAddr;
  logic [DivWidth-1:0]  divData;
  logic                 sysRst;
  logic [Channels-1:0]  chanRst;
  logic [Channels-1:0]  chanEn;
  logic                 ready;

  modport master (
    output softReset, divWe, divAddr, divData,
    input  sysRst, chanRst, chanEn, ready
  );

  modport slave (
    input  softReset, divWe, divAddr, divData,
    output sysRst, chanRst, chanEn, ready
  );
endinterface

// File: rtl/reset_clock_manager.sv
// Power-up reset sequencer with staggered per-channel release and
// per-channel programmable clock-enable strobes.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  POWERUP | sysRst held, counting out the power-up interval
//  SEQ     | releasing chanRst one channel per stagger interval
//  RUN     | all channels released, ready=1
//  HOLD    | soft reset: all channels held for one stagger interval
module reset_clock_manager #(
  parameter int Channels      = 4,
  parameter int AddrWidth     = 2,
  parameter int DivWidth      = 8,
  parameter int DefaultDiv    = 0,
  parameter int PowerupWidth  = 24,
  parameter int PowerupCount  = 6777216,
  parameter int StaggerCycles = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  reset_clock_manager_if.slave   bus
);

  localparam int IdxW  = (Channels > 1) ? $clog2(Channels) : 1;
  localparam int StagW = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;

  localparam logic [PowerupWidth-1:0] PuLast    = PowerupWidth'(PowerupCount - 1);
  localparam logic [StagW-1:0]        StagLast  = StagW'(StaggerCycles - 1);
  localparam logic [IdxW-1:0]         IdxLast   = IdxW'(Channels - 1);
  localparam logic [AddrWidth:0]      ChanLimit = (AddrWidth + 1)'(Channels);
  localparam logic [DivWidth-1:0]     DivReset  = DivWidth'(DefaultDiv);

  typedef enum logic [1:0] {
    POWERUP,
    SEQ,
    RUN,
    HOLD
  } state_t;

  state_t                  state, stateNext;
  logic [PowerupWidth-1:0] puCnt, puCntNext;
  logic [StagW-1:0]        stagCnt, stagCntNext;
  logic [IdxW-1:0]         idx, idxNext;
  logic [Channels-1:0]     chanRst, chanRstNext;
  logic                    sysRst, sysRstNext;
  logic                    ready, readyNext;

  logic [DivWidth-1:0]     divQ [Channels];
  logic [DivWidth-1:0]     cntQ [Channels];
  logic [Channels-1:0]     chanEn;
  logic [Channels-1:0]     wrHit;
  logic                    addrOk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= POWERUP;
      puCnt   <= '0;
      stagCnt <= '0;
      idx     <= '0;
      chanRst <= '1;
      sysRst  <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= stateNext;
      puCnt   <= puCntNext;
      stagCnt <= stagCntNext;
      idx     <= idxNext;
      chanRst <= chanRstNext;
      sysRst  <= sysRstNext;
      ready   <= readyNext;
    end
  end

  always_comb begin
    stateNext   = state;
    puCntNext   = puCnt;
    stagCntNext = stagCnt;
    idxNext     = idx;
    chanRstNext = chanRst;
    sysRstNext  = sysRst;
    readyNext   = ready;
    unique case (state)
      POWERUP: begin
        sysRstNext = 1'b1;
        if (puCnt == PuLast) begin
          stateNext   = SEQ;
          puCntNext   = '0;
          stagCntNext = '0;
          idxNext     = '0;
          sysRstNext  = 1'b0;
        end else begin
          puCntNext = puCnt + 1'b1;
        end
      end
      SEQ: begin
        // softReset takes priority over a release falling in the same cycle
        if (bus.softReset) begin
          stateNext   = HOLD;
          chanRstNext = '1;
          readyNext   = 1'b0;
          idxNext     = '0;
          stagCntNext = '0;
        end else if (stagCnt == StagLast) begin
          chanRstNext[idx] = 1'b0;
          stagCntNext      = '0;
          if (idx == IdxLast) begin
            stateNext = RUN;
            readyNext = 1'b1;
            idxNext   = '0;
          end else begin
            idxNext = idx + 1'b1;
          end
        end else begin
          stagCntNext = stagCnt + 1'b1;
        end
      end
      RUN: begin
        if (bus.softReset) begin
          stateNext   = HOLD;
          chanRstNext = '1;
          readyNext   = 1'b0;
          idxNext     = '0;
          stagCntNext = '0;
        end
      end
      HOLD: begin
        if (bus.softReset) begin
          stagCntNext = '0;
        end else if (stagCnt == StagLast) begin
          stateNext   = SEQ;
          stagCntNext = '0;
        end else begin
          stagCntNext = stagCnt + 1'b1;
        end
      end
      default: stateNext = POWERUP;
    endcase
  end

  always_comb begin
    wrHit  = '0;
    addrOk = ({1'b0, bus.divAddr} < ChanLimit);
    for (int i = 0; i < Channels; i++) begin
      wrHit[i] = bus.divWe && addrOk && (bus.divAddr == AddrWidth'(i));
    end
  end

  // Holding on the next chanRst as well keeps strobes off on the edge a channel re-enters reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Channels; i++) begin
        divQ[i] <= DivReset;
        cntQ[i] <= '0;
      end
      chanEn <= '0;
    end else begin
      for (int i = 0; i < Channels; i++) begin
        if (wrHit[i]) begin
          divQ[i]   <= bus.divData;
          cntQ[i]   <= '0;
          chanEn[i] <= 1'b0;
        end else if (chanRst[i] || chanRstNext[i]) begin
          cntQ[i]   <= '0;
          chanEn[i] <= 1'b0;
        end else if (cntQ[i] == divQ[i]) begin
          cntQ[i]   <= '0;
          chanEn[i] <= 1'b1;
        end else begin
          cntQ[i]   <= cntQ[i] + 1'b1;
          chanEn[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.sysRst  = sysRst;
  assign bus.chanRst = chanRst;
  assign bus.chanEn  = chanEn;
  assign bus.ready   = ready;

endmodule
